// File: rtl/jtag_host.sv
// JTAG host: accepts RESET / IRSCAN / DRSCAN / IDLE commands and drives the
// TAP pins with a divided TCK, returning the captured TDO bits as a response.
module jtag_host #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    output logic        trst,
    input  logic        tdo
);

    localparam int unsigned PHASE_W = 8;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned DATA_W  = 32;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);
    // Zero-length scans walk through Exit1/Update without shifting (bit i = TCK i).
    localparam logic [7:0] DR0_TMS = 8'b0000_1101;
    localparam logic [7:0] IR0_TMS = 8'b0001_1011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    typedef struct packed {
        logic       tms;
        logic       shift;
        logic [4:0] bit_idx;
    } plan_t;

    state_t               state, state_d;
    logic [1:0]           op_q, op_d;
    logic [IDX_W-1:0]     len_q, len_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 phase_hi_q, phase_hi_d;
    logic                 tck_d, tms_d, tdi_d, trst_d;
    logic                 cmd_ready_d, rsp_valid_d, busy_d;
    logic [DATA_W-1:0]    rsp_data_d;
    logic [IDX_W-1:0]     len_clamped, idx_nxt;
    plan_t                acc_plan, cur_plan, nxt_plan;

    // TMS value and shift position for TCK number idx of a command.
    function automatic plan_t tck_plan(input logic [1:0] op, input logic [IDX_W-1:0] len,
                                       input logic [IDX_W-1:0] idx);
        plan_t            p;
        logic [IDX_W-1:0] pre;
        logic [IDX_W-1:0] rel;
        p   = '0;
        pre = (op == OP_IR) ? IDX_W'(4) : IDX_W'(3);
        rel = IDX_W'(idx - pre);
        case (op)
            OP_RESET: p.tms = (idx < IDX_W'(5));
            OP_IDLE:  p.tms = 1'b0;
            default: begin
                if (len == '0) begin
                    p.tms = (op == OP_IR) ? IR0_TMS[idx[2:0]] : DR0_TMS[idx[2:0]];
                end else if (idx < pre) begin
                    p.tms = (idx == '0) || (op == OP_IR && idx == IDX_W'(1));
                end else if (rel < len) begin
                    p.shift   = 1'b1;
                    p.bit_idx = rel[4:0];
                    p.tms     = (rel == IDX_W'(len - IDX_W'(1)));
                end else begin
                    p.tms = (rel == len);
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [IDX_W-1:0] tck_total(input logic [1:0] op, input logic [IDX_W-1:0] len);
        case (op)
            OP_RESET: return IDX_W'(6);
            OP_IR:    return IDX_W'(len + IDX_W'(6));
            OP_DR:    return IDX_W'(len + IDX_W'(5));
            default:  return len;
        endcase
    endfunction

    assign len_clamped = (cmd_len > IDX_W'(32)) ? IDX_W'(32) : cmd_len;
    assign idx_nxt     = IDX_W'(idx_q + IDX_W'(1));
    assign acc_plan    = tck_plan(cmd_op, len_clamped, '0);
    assign cur_plan    = tck_plan(op_q, len_q, idx_q);
    assign nxt_plan    = tck_plan(op_q, len_q, idx_nxt);

    always_comb begin
        state_d     = state;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        phase_hi_d  = phase_hi_q;
        tck_d       = tck;
        tms_d       = tms;
        tdi_d       = tdi;
        trst_d      = trst;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op;
                    len_d      = len_clamped;
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    idx_d      = '0;
                    phase_d    = '0;
                    phase_hi_d = 1'b0;
                    tck_d      = 1'b0;
                    if (tck_total(cmd_op, len_clamped) == '0) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        tms_d   = acc_plan.tms;
                        tdi_d   = acc_plan.shift ? cmd_data[acc_plan.bit_idx] : 1'b0;
                        trst_d  = (cmd_op != OP_RESET);
                    end
                end
            end
            S_RUN: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (!phase_hi_q) begin
                        tck_d      = 1'b1;
                        phase_hi_d = 1'b1;
                        if (cur_plan.shift) begin
                            rsp_data_d[cur_plan.bit_idx] = tdo;
                        end
                    end else begin
                        tck_d      = 1'b0;
                        phase_hi_d = 1'b0;
                        if (idx_q == IDX_W'(tck_total(op_q, len_q) - IDX_W'(1))) begin
                            state_d     = S_RESP;
                            rsp_valid_d = 1'b1;
                        end else begin
                            idx_d  = idx_nxt;
                            tms_d  = nxt_plan.tms;
                            tdi_d  = nxt_plan.shift ? data_q[nxt_plan.bit_idx] : 1'b0;
                            trst_d = !(op_q == OP_RESET && idx_nxt < IDX_W'(5));
                        end
                    end
                end else begin
                    phase_d = PHASE_W'(phase_q + PHASE_W'(1));
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            len_q      <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            phase_q    <= '0;
            phase_hi_q <= 1'b0;
            tck        <= 1'b0;
            tms        <= 1'b1;
            tdi        <= 1'b0;
            trst       <= 1'b1;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            op_q       <= op_d;
            len_q      <= len_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            phase_hi_q <= phase_hi_d;
            tck        <= tck_d;
            tms        <= tms_d;
            tdi        <= tdi_d;
            trst       <= trst_d;
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host with CLK_DIV=2: logs each command's TCK train
// and response and compares it with hand-derived TAP sequences.
module tb_jtag_host;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck, tms, tdi, trst;
    logic        tdo;

    int n_tests = 0;
    int n_fail  = 0;

    // per-command log
    int          pulses, lat, width_err, trst_low;
    logic [63:0] tms_seq, tdi_seq;
    logic [31:0] tdo_pat;
    int          tdo_start;

    jtag_host #(.CLK_DIV(2)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .trst      (trst),
        .tdo       (tdo)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one command, scramble the inputs after acceptance, then log the TCK train.
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int   guard;
        int   run_len;
        logic prev_tck;
        guard = 0;
        @(negedge sys_clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge sys_clk);
            guard++;
        end
        check("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_len   = 6'd17;
        cmd_data  = ~data;
        pulses = 0; lat = 0; width_err = 0; trst_low = 0;
        tms_seq = '0; tdi_seq = '0;
        prev_tck = 1'b0;
        run_len  = 0;
        tdo = (tdo_start == 0) ? tdo_pat[0] : 1'b0;
        forever begin
            if (tck !== prev_tck) begin
                if (run_len != 2) width_err++;
                run_len = 1;
                if (tck === 1'b1) begin
                    tms_seq[pulses] = tms;
                    tdi_seq[pulses] = tdi;
                    pulses++;
                end
            end else begin
                run_len++;
            end
            prev_tck = tck;
            if (trst === 1'b0) trst_low++;
            if (pulses >= tdo_start && pulses < tdo_start + 32)
                tdo = tdo_pat[pulses - tdo_start];
            else
                tdo = 1'b0;
            if (rsp_valid === 1'b1 || lat >= 2000) break;
            @(posedge sys_clk);
            #1;
            lat++;
        end
    endtask

    // Hold off rsp_ready, checking the response stays put, then handshake.
    task automatic hold_and_release(input int n, input logic [31:0] exp_data);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || cmd_ready !== 1'b0 || tck !== 1'b0)
                bad++;
            @(posedge sys_clk);
            #1;
        end
        check("rsp_hold_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        rsp_ready = 1'b0;
        check("cmd_ready_after_handshake", 64'(cmd_ready), 64'd1);
        check("busy_after_handshake", 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0;
        rsp_ready = 1'b0; tdo = 1'b0; tdo_pat = '1; tdo_start = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_outputs",
              {52'd0, tck, tms, tdi, trst, cmd_ready, rsp_valid, busy, 5'd0},
              {52'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge sys_clk);
        reset = 1'b0;
        @(posedge sys_clk);
        #1;
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // RESET op
        tdo_pat = '1; tdo_start = 0;
        run_cmd(2'b00, 6'd0, 32'hFFFF_FFFF);
        check("reset_pulses", 64'(pulses), 64'd6);
        check("reset_tms", tms_seq, 64'h1F);
        check("reset_trst_low", 64'(trst_low), 64'd20);
        check("reset_width", 64'(width_err), 64'd0);
        check("reset_rsp", 64'(rsp_data), 64'd0);
        check("reset_latency", 64'(lat), 64'd24);
        hold_and_release(10, 32'd0);

        // IRSCAN len 4
        tdo_pat = 32'hFFFF_FFFA; tdo_start = 4;
        run_cmd(2'b01, 6'd4, 32'h0000_0001);
        check("ir4_pulses", 64'(pulses), 64'd10);
        check("ir4_tms", tms_seq, 64'h183);
        check("ir4_tdi", tdi_seq, 64'h10);
        check("ir4_latency", 64'(lat), 64'd40);
        check("ir4_width", 64'(width_err), 64'd0);
        check("ir4_trst_low", 64'(trst_low), 64'd0);
        check("ir4_rsp", 64'(rsp_data), 64'hA);
        hold_and_release(2, 32'hA);

        // DRSCAN len 32
        tdo_pat = 32'h1234_5678; tdo_start = 3;
        run_cmd(2'b10, 6'd32, 32'hCAFE_F00D);
        check("dr32_pulses", 64'(pulses), 64'd37);
        check("dr32_tms", tms_seq, 64'h0000_000C_0000_0001);
        check("dr32_tdi", tdi_seq, 64'h0000_0006_57F7_8068);
        check("dr32_rsp", 64'(rsp_data), 64'h1234_5678);
        check("dr32_latency", 64'(lat), 64'd148);
        hold_and_release(1, 32'h1234_5678);

        // DRSCAN len 0
        tdo_pat = '1; tdo_start = 3;
        run_cmd(2'b10, 6'd0, 32'hFFFF_FFFF);
        check("dr0_pulses", 64'(pulses), 64'd5);
        check("dr0_tms", tms_seq, 64'hD);
        check("dr0_tdi", tdi_seq, 64'h0);
        check("dr0_rsp", 64'(rsp_data), 64'd0);
        hold_and_release(1, 32'd0);

        // IRSCAN len 0
        tdo_pat = '1; tdo_start = 4;
        run_cmd(2'b01, 6'd0, 32'hFFFF_FFFF);
        check("ir0_pulses", 64'(pulses), 64'd6);
        check("ir0_tms", tms_seq, 64'h1B);
        check("ir0_rsp", 64'(rsp_data), 64'd0);
        hold_and_release(1, 32'd0);

        // IDLE len 0 and len 3
        run_cmd(2'b11, 6'd0, 32'hFFFF_FFFF);
        check("idle0_pulses", 64'(pulses), 64'd0);
        check("idle0_latency", 64'(lat), 64'd0);
        hold_and_release(1, 32'd0);
        tdo_pat = '1; tdo_start = 0;
        run_cmd(2'b11, 6'd3, 32'hFFFF_FFFF);
        check("idle3_pulses", 64'(pulses), 64'd3);
        check("idle3_tms", tms_seq, 64'h0);
        check("idle3_latency", 64'(lat), 64'd12);
        check("idle3_rsp", 64'(rsp_data), 64'd0);
        hold_and_release(1, 32'd0);

        // length above 32 clamps to 32
        tdo_pat = 32'h0F0F_0F0F; tdo_start = 3;
        run_cmd(2'b10, 6'd40, 32'd0);
        check("dr40_pulses", 64'(pulses), 64'd37);
        check("dr40_rsp", 64'(rsp_data), 64'h0F0F_0F0F);
        hold_and_release(1, 32'h0F0F_0F0F);

        // reset in the middle of a DRSCAN len 32
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd32; cmd_data = 32'hFFFF_FFFF;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && seen < 10; i++) begin
            logic was;
            was = tck;
            @(posedge sys_clk);
            #1;
            if (!was && tck) seen++;
        end
        check("midreset_reached_tck10", 64'(seen), 64'd10);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_tck", 64'(tck), 64'd0);
        check("midreset_tms", 64'(tms), 64'd1);
        check("midreset_busy", 64'(busy), 64'd0);
        @(negedge sys_clk);
        reset = 1'b0;
        @(posedge sys_clk);
        #1;
        check("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid !== 1'b0 || tck !== 1'b0) seen++;
            @(posedge sys_clk);
            #1;
        end
        check("midreset_no_rsp", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
